tone_i2s_speaker: RTL and testbench

Audio back end of the music player. Converts the per-channel tone frequencies (Hz, 32-bit; the silence code 32'd1_0000_0000 or any inaudible value) produced by the note/score logic into ±amplitude square waves, then streams them as 16-bit two's-complement stereo I2S to the Pmod audio DAC. It owns all DAC clocks (MCLK/LRCK/SCK) and the serial data line.

---
 rtl/tone_i2s_speaker.sv | 119 +++++++++++
 tb/tb_tone_i2s_speaker.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_i2s_speaker.sv
// Stereo square-wave tone synthesiser feeding a Pmod I2S DAC.
// Owns the DAC clock divider, per-channel phase accumulators, frame latch and serializer.
module tone_i2s_speaker #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SIL_MIN = 20_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] toneL,
    input  logic [31:0] toneR,
    input  logic [2:0]  volume,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin,
    output logic        sq_l,
    output logic        sq_r
);

    typedef struct packed {
        logic [31:0] acc;
        logic        sq;
    } tone_t;

    // Accumulates 2*f per clk modulo CLK_HZ; each wrap is one half-period of the square wave.
    function automatic tone_t tone_step(input tone_t cur, input logic [31:0] tone, input logic silent);
        tone_t       nxt;
        logic [32:0] s;
        nxt = cur;
        s   = {1'b0, cur.acc} + {tone, 1'b0};
        if (silent) begin
            nxt = '0;
        end else if (s >= 33'(CLK_HZ)) begin
            nxt.acc = 32'(s - 33'(CLK_HZ));
            nxt.sq  = ~cur.sq;
        end else begin
            nxt.acc = s[31:0];
        end
        return nxt;
    endfunction

    function automatic logic [15:0] amplitude(input logic [2:0] vol);
        case (vol)
            3'd0:    return 16'h0000;
            3'd1:    return 16'h0400;
            3'd2:    return 16'h0800;
            3'd3:    return 16'h1000;
            3'd4:    return 16'h2000;
            default: return 16'h4000;
        endcase
    endfunction

    function automatic logic [15:0] sample(input logic sq, input logic silent, input logic [15:0] amp);
        if (silent) return 16'h0000;
        return sq ? amp : (~amp + 16'd1);
    endfunction

    logic [9:0]  cnt_q, cnt_d;
    tone_t       tl_q, tl_d, tr_q, tr_d;
    logic [15:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic        sdin_q, sdin_d;

    logic        silent_l, silent_r;
    logic [15:0] amp;
    logic [4:0]  slot;
    logic [15:0] word;

    assign silent_l = !en || (toneL == 32'd0) || (toneL >= SIL_MIN);
    assign silent_r = !en || (toneR == 32'd0) || (toneR >= SIL_MIN);
    assign amp      = amplitude(volume);

    always_comb begin
        cnt_d     = cnt_q + 10'd1;
        tl_d      = tone_step(tl_q, toneL, silent_l);
        tr_d      = tone_step(tr_q, toneR, silent_r);
        frame_l_d = frame_l_q;
        frame_r_d = frame_r_q;
        if (cnt_q == 10'd1023) begin
            frame_l_d = sample(tl_q.sq, silent_l, amp);
            frame_r_d = sample(tr_q.sq, silent_r, amp);
        end
        // NOTE: sdin is registered, so it is computed for the count it will hold next (cnt_d);
        // slot 0 is always zero, which hides the frame register update at the wrap.
        slot   = cnt_d[8:4];
        word   = cnt_d[9] ? frame_r_q : frame_l_q;
        sdin_d = 1'b0;
        if (slot >= 5'd1 && slot <= 5'd16) begin
            sdin_d = word[4'(5'd16 - slot)];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            tl_q      <= '0;
            tr_q      <= '0;
            frame_l_q <= '0;
            frame_r_q <= '0;
            sdin_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tl_q      <= tl_d;
            tr_q      <= tr_d;
            frame_l_q <= frame_l_d;
            frame_r_q <= frame_r_d;
            sdin_q    <= sdin_d;
        end
    end

    assign audio_mclk = cnt_q[1];
    assign audio_sck  = cnt_q[3];
    assign audio_lrck = cnt_q[9];
    assign audio_sdin = sdin_q;
    assign sq_l       = tl_q.sq;
    assign sq_r       = tr_q.sq;

endmodule

// File: tb/tb_tone_i2s_speaker.sv
// Directed bench for tone_i2s_speaker: decodes the I2S stream from the pins and checks
// words, clocks and square-wave timing (clock modulus scaled to 1 MHz to keep runs short).
module tb_tone_i2s_speaker;

    localparam int unsigned CLK_HZ = 1_000_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] tone_l = '0;
    logic [31:0] tone_r = '0;
    logic [2:0]  volume = '0;
    logic        audio_mclk, audio_lrck, audio_sck, audio_sdin, sq_l, sq_r;

    tone_i2s_speaker #(.CLK_HZ(CLK_HZ), .SIL_MIN(20_000)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .toneL     (tone_l),
        .toneR     (tone_r),
        .volume    (volume),
        .audio_mclk(audio_mclk),
        .audio_lrck(audio_lrck),
        .audio_sck (audio_sck),
        .audio_sdin(audio_sdin),
        .sq_l      (sq_l),
        .sq_r      (sq_r)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 95_000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    typedef struct {
        logic        en;
        logic [31:0] tl;
        logic [31:0] tr;
        logic [2:0]  vol;
        logic [15:0] mag_l;
        logic [15:0] mag_r;
    } vec_t;

    vec_t        vecs[12];
    int          n_pass = 0;
    int          n_total = 0;
    logic [63:0] cap_bits;
    logic [15:0] word_l, word_r;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Word must be +mag or -mag (two's complement); the sign depends on square-wave phase.
    task automatic check_mag(input string name, input logic [15:0] got, input logic [15:0] mag);
        logic [15:0] neg;
        neg = ~mag + 16'd1;
        check(name, {16'h0, got}, {16'h0, (got == neg) ? neg : mag});
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return audio_mclk;
            1:       return audio_sck;
            default: return audio_lrck;
        endcase
    endfunction

    // Returns at the negedge right after cnt wrapped to 0 (LRCK falling).
    task automatic wait_wrap;
        logic prev;
        logic found;
        prev  = audio_lrck;
        found = 1'b0;
        for (int n = 0; n < 1100 && !found; n++) begin
            tick();
            if (prev && !audio_lrck) found = 1'b1;
            prev = audio_lrck;
        end
        check("wrap_seen", {31'h0, found}, 32'd1);
    endtask

    // Called with cnt == 0; samples sdin at all 64 SCK rises of the frame.
    task automatic capture_frame;
        logic prev;
        logic pad;
        int   slot;
        prev = audio_sck;
        slot = 0;
        for (int g = 0; g < 1100 && slot < 64; g++) begin
            tick();
            if (audio_sck && !prev) begin
                cap_bits[slot] = audio_sdin;
                slot++;
            end
            prev = audio_sck;
        end
        check("capture_slots", slot, 64);
        for (int k = 0; k < 16; k++) begin
            word_l[15-k] = cap_bits[1+k];
            word_r[15-k] = cap_bits[33+k];
        end
        pad = cap_bits[0] | cap_bits[32] | (|cap_bits[31:17]) | (|cap_bits[63:49]);
        check("pad_slots_zero", {31'h0, pad}, 32'd0);
    endtask

    task automatic period(input int sel, output int per);
        logic prev, cur, seen;
        int   n;
        prev = sig(sel);
        seen = 1'b0;
        per  = 0;
        n    = 0;
        for (int g = 0; g < 3000; g++) begin
            tick();
            n++;
            cur = sig(sel);
            if (cur && !prev) begin
                if (seen) begin
                    per = n;
                    return;
                end
                seen = 1'b1;
                n    = 0;
            end
            prev = cur;
        end
    endtask

    initial begin
        int   n, sum, per, rises;
        logic prev, found;

        vecs[0]  = '{1'b1, 32'd330,   32'd330,   3'd0, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 32'd330,   32'd330,   3'd1, 16'h0400, 16'h0400};
        vecs[2]  = '{1'b1, 32'd330,   32'd330,   3'd2, 16'h0800, 16'h0800};
        vecs[3]  = '{1'b1, 32'd330,   32'd330,   3'd3, 16'h1000, 16'h1000};
        vecs[4]  = '{1'b1, 32'd330,   32'd330,   3'd4, 16'h2000, 16'h2000};
        vecs[5]  = '{1'b1, 32'd330,   32'd330,   3'd5, 16'h4000, 16'h4000};
        vecs[6]  = '{1'b1, 32'd330,   32'd330,   3'd6, 16'h4000, 16'h4000};
        vecs[7]  = '{1'b1, 32'd330,   32'd330,   3'd7, 16'h4000, 16'h4000};
        vecs[8]  = '{1'b1, 32'd440,   32'd440,   3'd3, 16'h1000, 16'h1000};
        vecs[9]  = '{1'b0, 32'd523,   32'd523,   3'd5, 16'h0000, 16'h0000};
        vecs[10] = '{1'b1, 32'd0,     32'd262,   3'd5, 16'h0000, 16'h4000};
        vecs[11] = '{1'b1, 32'd20000, 32'd19999, 3'd1, 16'h0000, 16'h0400};

        // Reset state
        repeat (3) tick();
        check("reset_outputs", {26'h0, audio_mclk, audio_lrck, audio_sck, audio_sdin, sq_l, sq_r}, 32'd0);
        rst = 1'b0;

        // Table: inputs applied near frame end, words checked on the following frame
        for (int i = 0; i < 12; i++) begin
            en = vecs[i].en; tone_l = vecs[i].tl; tone_r = vecs[i].tr; volume = vecs[i].vol;
            wait_wrap();
            capture_frame();
            check_mag($sformatf("vec%0d_left", i), word_l, vecs[i].mag_l);
            check_mag($sformatf("vec%0d_right", i), word_r, vecs[i].mag_r);
        end

        // Serial format: L toggles at clk 1000 (500 Hz), R not before 5000 (100 Hz)
        en = 1'b0; volume = 3'd5;
        wait_wrap();
        en = 1'b1; tone_l = 32'd500; tone_r = 32'd100;
        wait_wrap();
        capture_frame();
        check("fmt_word_l", {16'h0, word_l}, 32'h4000);
        check("fmt_word_r", {16'h0, word_r}, 32'hC000);
        check("fmt_msb_l_slot1", {31'h0, cap_bits[1]}, 32'd0);
        check("fmt_msb_r_slot1", {31'h0, cap_bits[33]}, 32'd1);

        // en gating, then re-enable 24 clk before a latch: first word is the negative half
        tone_l = 32'd523; tone_r = 32'd523; volume = 3'd5; en = 1'b0;
        wait_wrap();
        capture_frame();
        check("en0_word_l", {16'h0, word_l}, 32'h0);
        check("en0_word_r", {16'h0, word_r}, 32'h0);
        wait_wrap();
        repeat (1000) tick();
        en = 1'b1;
        wait_wrap();
        capture_frame();
        check("en1_first_l", {16'h0, word_l}, 32'hC000);
        check("en1_first_r", {16'h0, word_r}, 32'hC000);
        wait_wrap();
        capture_frame();
        check("en1_second_l", {16'h0, word_l}, 32'h4000);
        check("en1_second_r", {16'h0, word_r}, 32'h4000);

        // Volume change just after a latch only shows in the frame after
        tone_l = 32'd330; tone_r = 32'd330; volume = 3'd2;
        wait_wrap();
        volume = 3'd4;
        capture_frame();
        check_mag("vol_old_frame_l", word_l, 16'h0800);
        check_mag("vol_old_frame_r", word_r, 16'h0800);
        wait_wrap();
        capture_frame();
        check_mag("vol_new_frame_l", word_l, 16'h2000);
        check_mag("vol_new_frame_r", word_r, 16'h2000);

        // Silence entry while sq is high
        en = 1'b0; tick();
        en = 1'b1; tone_l = 32'd440; tone_r = 32'd440; volume = 3'd3;
        found = 1'b0;
        for (int g = 0; g < 2000 && !found; g++) begin
            tick();
            if (sq_l && sq_r) found = 1'b1;
        end
        check("sq_high_seen", {31'h0, found}, 32'd1);
        tone_l = 32'd100_000_000; tone_r = 32'd0;
        tick();
        check("silence_sq_l", {31'h0, sq_l}, 32'd0);
        check("silence_sq_r", {31'h0, sq_r}, 32'd0);
        wait_wrap();
        capture_frame();
        check("silence_word_l", {16'h0, word_l}, 32'h0);
        check("silence_word_r", {16'h0, word_r}, 32'h0);

        // 440 Hz: half period 1e6/880 = 1136.36 clk; 11 half periods are exactly 12500 clk
        tone_l = 32'd440; tone_r = 32'd440;
        prev = sq_l;
        found = 1'b0;
        for (int g = 0; g < 1300 && !found; g++) begin
            tick();
            if (sq_l != prev) found = 1'b1;
            prev = sq_l;
        end
        check("first_toggle_seen", {31'h0, found}, 32'd1);
        sum = 0;
        for (int k = 0; k < 11; k++) begin
            n = 0;
            found = 1'b0;
            for (int g = 0; g < 1300 && !found; g++) begin
                tick();
                n++;
                if (sq_l != prev) found = 1'b1;
                prev = sq_l;
            end
            sum += n;
            check($sformatf("interval_%0d", k), n, (n == 1137) ? 32'd1137 : 32'd1136);
        end
        check("interval_sum_11", sum, 32'd12500);
        wait_wrap();
        capture_frame();
        check_mag("tone440_word_l", word_l, 16'h1000);
        check_mag("tone440_word_r", word_r, 16'h1000);

        // Mid-run reset and clock relationships after release
        repeat (300) tick();
        rst = 1'b1;
        #1;
        check("rst_immediate", {26'h0, audio_mclk, audio_lrck, audio_sck, audio_sdin, sq_l, sq_r}, 32'd0);
        repeat (5) tick();
        check("rst_held", {26'h0, audio_mclk, audio_lrck, audio_sck, audio_sdin, sq_l, sq_r}, 32'd0);
        rst = 1'b0;
        n = 0;
        found = 1'b0;
        for (int g = 0; g < 600 && !found; g++) begin
            tick();
            n++;
            if (audio_lrck) found = 1'b1;
        end
        check("lrck_first_rise", n, 32'd512);
        period(1, per);
        check("sck_period", per, 32'd16);
        period(0, per);
        check("mclk_period", per, 32'd4);
        period(2, per);
        check("lrck_period", per, 32'd1024);
        // Now just after an LRCK rise: count SCK rises until the next one
        rises = 0;
        found = 1'b0;
        prev = audio_sck;
        begin
            logic lr_prev;
            lr_prev = audio_lrck;
            for (int g = 0; g < 1100 && !found; g++) begin
                tick();
                if (audio_sck && !prev) rises++;
                if (audio_lrck && !lr_prev) found = 1'b1;
                prev = audio_sck;
                lr_prev = audio_lrck;
            end
        end
        check("sck_per_lrck", rises, 32'd64);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
